// File: rtl/alu_activity_mon_if.sv
// ---------------------------------------------------------------------------
// alu_activity_mon_if
// Bus bundle between an ALU-side host and the alu_activity_mon block.
//   Sample side (host -> monitor): smp_valid, smp_en, smp_op, smp_a, smp_b, smp_y
//   Dump stream (monitor -> host): rd_valid, rd_op, rd_toggles, rd_count,
//                                  rd_last (+ rd_a_hw, rd_b_hw when
//                                  ALU_HW_STATS_EN is defined)
//   Dump stream (host -> monitor): rd_ready
// Modports: master = host/logger side, slave = monitor side.
// Optional feature macro: ALU_HW_STATS_EN (adds operand Hamming-weight rows).
// ---------------------------------------------------------------------------
interface alu_activity_mon_if #(
   parameter int W    = 16,
   parameter int OPW  = 4,
   parameter int CNTW = 32
);
   logic            smp_valid;
   logic            smp_en;
   logic [OPW-1:0]  smp_op;
   logic [W-1:0]    smp_a;
   logic [W-1:0]    smp_b;
   logic [W-1:0]    smp_y;

   logic            rd_valid;
   logic            rd_ready;
   logic [OPW-1:0]  rd_op;
   logic [CNTW-1:0] rd_toggles;
   logic [CNTW-1:0] rd_count;
   logic            rd_last;
`ifdef ALU_HW_STATS_EN
   logic [CNTW-1:0] rd_a_hw;
   logic [CNTW-1:0] rd_b_hw;
`endif

   modport master (
      output smp_valid, smp_en, smp_op, smp_a, smp_b, smp_y, rd_ready,
`ifdef ALU_HW_STATS_EN
      input  rd_a_hw, rd_b_hw,
`endif
      input  rd_valid, rd_op, rd_toggles, rd_count, rd_last
   );

   modport slave (
      input  smp_valid, smp_en, smp_op, smp_a, smp_b, smp_y, rd_ready,
`ifdef ALU_HW_STATS_EN
      output rd_a_hw, rd_b_hw,
`endif
      output rd_valid, rd_op, rd_toggles, rd_count, rd_last
   );
endinterface

// File: rtl/alu_activity_mon.sv
// ---------------------------------------------------------------------------
// alu_activity_mon
// Switching-activity monitor for ALU power characterisation. Samples the ALU
// result stream, accumulates per-opcode result toggle counts over a window of
// WIN valid samples, then streams one row per opcode over a valid/ready port.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   start      begin a window (honoured in IDLE only)
//   busy       state != IDLE
//   gated_cnt  samples in the window taken with smp_en = 0
//   drop_cnt   samples discarded while dumping
//   bus        alu_activity_mon_if.slave: sample inputs and dump stream
//
// Optional feature macro: ALU_HW_STATS_EN -- adds per-opcode Hamming-weight
// accumulators for operands a and b, reported as rd_a_hw / rd_b_hw.
// All counters saturate at 2**CNTW-1.
// ---------------------------------------------------------------------------
module alu_activity_mon #(
   parameter int W    = 16,
   parameter int OPW  = 4,
   parameter int CNTW = 32,
   parameter int WIN  = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic [CNTW-1:0]  gated_cnt,
   output logic [CNTW-1:0]  drop_cnt,
   alu_activity_mon_if.slave bus
);

   localparam int NOP = 2 ** OPW;
   localparam int TW  = $clog2(W + 1);
   // Sum width wide enough for either operand plus a carry, so a per-sample
   // increment larger than the counter itself still saturates correctly.
   localparam int SW  = ((CNTW > TW) ? CNTW : TW) + 1;
   localparam int WCW = $clog2(WIN + 1);
   localparam logic [SW-1:0] SAT_MAX = SW'({CNTW{1'b1}});

   function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] acc,
                                                input logic [TW-1:0]   inc);
      logic [SW-1:0] sum;
      sum = SW'(acc) + SW'(inc);
      if (sum > SAT_MAX)
         return {CNTW{1'b1}};
      else
         return sum[CNTW-1:0];
   endfunction

   function automatic logic [TW-1:0] popcount(input logic [W-1:0] v);
      logic [TW-1:0] n;
      n = '0;
      for (int i = 0; i < W; i++)
         n = n + TW'(v[i]);
      return n;
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DUMP} state_t;
   state_t state_reg, state_next;

   logic [W-1:0]    prev_y_reg;
   logic [WCW-1:0]  win_cnt_reg;
   logic [CNTW-1:0] gated_cnt_reg, drop_cnt_reg;
   logic [OPW-1:0]  rd_op_reg;
   logic [CNTW-1:0] rd_toggles_reg, rd_count_reg;
   logic            rd_valid_int;

   logic            clr, acc_en, win_last, rd_accept, last_accept, load_row;
   logic [TW-1:0]   tog_inc;
   logic [OPW-1:0]  row_sel;

   // Accumulator values after this cycle's sample; the row loader reads these
   // so the window's final sample is visible in row 0 on the first DUMP cycle.
   logic [CNTW-1:0] tog_next [NOP];
   logic [CNTW-1:0] cnt_next [NOP];

   // ---------------- control ----------------
   always_comb begin
      clr         = (state_reg == S_IDLE) && start;
      acc_en      = (state_reg == S_ACCUM) && bus.smp_valid;
      win_last    = acc_en && (win_cnt_reg == WCW'(WIN - 1));
      rd_accept   = (state_reg == S_DUMP) && bus.rd_ready;
      last_accept = rd_accept && (rd_op_reg == OPW'(NOP - 1));
      load_row    = win_last || rd_accept;
      row_sel     = win_last ? '0 : (rd_op_reg + OPW'(1));
      tog_inc     = popcount(bus.smp_y ^ prev_y_reg);
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start)       state_next = S_ACCUM;
         S_ACCUM: if (win_last)    state_next = S_DUMP;
         S_DUMP:  if (last_accept) state_next = S_IDLE;
         default:                  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_reg != S_IDLE);
      rd_valid_int = (state_reg == S_DUMP);
   end

   // ---------------- per-opcode accumulators ----------------
   generate
      for (genvar gi = 0; gi < NOP; gi++) begin : g_op
         logic            hit;
         logic [CNTW-1:0] tog_reg, cnt_reg;

         assign hit          = acc_en && (bus.smp_op == OPW'(gi));
         assign tog_next[gi] = hit ? sat_add(tog_reg, tog_inc) : tog_reg;
         assign cnt_next[gi] = hit ? sat_add(cnt_reg, TW'(1))  : cnt_reg;

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               tog_reg <= '0;
               cnt_reg <= '0;
            end else begin
               tog_reg <= tog_next[gi];
               cnt_reg <= cnt_next[gi];
            end
         end
      end
   endgenerate

`ifdef ALU_HW_STATS_EN
   logic [TW-1:0]   a_hw_inc, b_hw_inc;
   logic [CNTW-1:0] ahw_next [NOP];
   logic [CNTW-1:0] bhw_next [NOP];
   logic [CNTW-1:0] rd_a_hw_reg, rd_b_hw_reg;

   assign a_hw_inc = popcount(bus.smp_a);
   assign b_hw_inc = popcount(bus.smp_b);

   generate
      for (genvar gi = 0; gi < NOP; gi++) begin : g_hw
         logic            hit;
         logic [CNTW-1:0] ahw_reg, bhw_reg;

         assign hit          = acc_en && (bus.smp_op == OPW'(gi));
         assign ahw_next[gi] = hit ? sat_add(ahw_reg, a_hw_inc) : ahw_reg;
         assign bhw_next[gi] = hit ? sat_add(bhw_reg, b_hw_inc) : bhw_reg;

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               ahw_reg <= '0;
               bhw_reg <= '0;
            end else begin
               ahw_reg <= ahw_next[gi];
               bhw_reg <= bhw_next[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_a_hw_reg <= '0;
         rd_b_hw_reg <= '0;
      end else if (load_row) begin
         rd_a_hw_reg <= ahw_next[row_sel];
         rd_b_hw_reg <= bhw_next[row_sel];
      end
   end

   assign bus.rd_a_hw = rd_a_hw_reg;
   assign bus.rd_b_hw = rd_b_hw_reg;
`else
   // Operands only feed the optional Hamming-weight statistics.
   logic unused_operands;
   assign unused_operands = ^{bus.smp_a, bus.smp_b};
`endif

   // ---------------- dump row registers ----------------
   // Loaded on entry to DUMP (row 0) and on every accept (next row); held
   // otherwise, so the row is stable under backpressure. The accept of the
   // last row wraps rd_op back to 0, which is harmless as rd_valid drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_op_reg      <= '0;
         rd_toggles_reg <= '0;
         rd_count_reg   <= '0;
      end else if (load_row) begin
         rd_op_reg      <= row_sel;
         rd_toggles_reg <= tog_next[row_sel];
         rd_count_reg   <= cnt_next[row_sel];
      end
   end

   // ---------------- window / side counters ----------------
   always_ff @(posedge clk) begin
      if (rst)
         prev_y_reg <= '0;
      else if (bus.smp_valid)
         prev_y_reg <= bus.smp_y;
   end

   always_ff @(posedge clk) begin
      if (rst || clr)
         win_cnt_reg <= '0;
      else if (acc_en)
         win_cnt_reg <= win_cnt_reg + WCW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst || clr)
         gated_cnt_reg <= '0;
      else if (acc_en && !bus.smp_en)
         gated_cnt_reg <= sat_add(gated_cnt_reg, TW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst || clr)
         drop_cnt_reg <= '0;
      else if ((state_reg == S_DUMP) && bus.smp_valid)
         drop_cnt_reg <= sat_add(drop_cnt_reg, TW'(1));
   end

   // ---------------- outputs ----------------
   assign bus.rd_valid   = rd_valid_int;
   assign bus.rd_op      = rd_op_reg;
   assign bus.rd_toggles = rd_toggles_reg;
   assign bus.rd_count   = rd_count_reg;
   assign bus.rd_last    = (rd_op_reg == OPW'(NOP - 1));
   assign gated_cnt      = gated_cnt_reg;
   assign drop_cnt       = drop_cnt_reg;

endmodule
